// File: rtl/shift_unit_iter.sv
// Multi-cycle shift/rotate unit for the execute stage.
// Six modes (SLL/SRL/SLA/SRA/ROL/ROR). The unit shifts STEP bits per enabled cycle
// under a start/busy/done handshake and reports cf/zf/nf flags alongside the result.
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous active-low reset
//   enable  - when high the FSM advances; when low all state and outputs hold
//   start   - request, accepted in IDLE or DONE while enable is high
//   mode    - 000 SLL, 001 SRL, 010 SLA, 011 SRA, 100 ROL, 101 ROR, 11x reserved
//   operand - data to shift, captured when a request is accepted
//   amount  - shift count 0..WIDTH-1, captured when a request is accepted
//   busy    - high while shifting
//   done    - high while the result is being presented
//   result  - shifted value, updated only on entry to DONE
//   cf      - last bit shifted/rotated out (0 for amount 0 or a reserved mode)
//   zf      - result == 0
//   nf      - result MSB
module shift_unit_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             zf,
  output logic             nf
);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SLA = 3'b010;
  localparam logic [2:0] MODE_SRA = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_ROR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [2:0]       mode_q,   mode_d;
  logic [AMT_W-1:0] rem_q,    rem_d;
  logic             cf_int_q, cf_int_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cf_q,     cf_d;
  logic             zf_q,     zf_d;
  logic             nf_q,     nf_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] step_w;
  logic             step_c;

  // One 1-bit step of the selected mode; returns {carry_out, new_value}.
  function automatic logic [WIDTH:0] step1(input logic [WIDTH-1:0] v,
                                           input logic [2:0]       m);
    logic [WIDTH-1:0] nv;
    logic             c;
    nv = v;
    c  = 1'b0;
    case (m)
      MODE_SLL: begin
        nv = {v[WIDTH-2:0], 1'b0};
        c  = v[WIDTH-1];
      end
      MODE_SRL: begin
        nv = {1'b0, v[WIDTH-1:1]};
        c  = v[0];
      end
      MODE_SLA: begin
        // Sign bit stays put; only the magnitude bits move.
        nv          = {v[WIDTH-2:0], 1'b0};
        nv[WIDTH-1] = v[WIDTH-1];
        c           = v[WIDTH-2];
      end
      MODE_SRA: begin
        nv = {v[WIDTH-1], v[WIDTH-1:1]};
        c  = v[0];
      end
      MODE_ROL: begin
        nv = {v[WIDTH-2:0], v[WIDTH-1]};
        c  = v[WIDTH-1];
      end
      MODE_ROR: begin
        nv = {v[0], v[WIDTH-1:1]};
        c  = v[0];
      end
      default: begin
        nv = v;
        c  = 1'b0;
      end
    endcase
    return {c, nv};
  endfunction

  // Datapath for one SHIFT cycle: min(STEP, rem) chained 1-bit steps.
  always_comb begin
    logic [WIDTH:0] tmp;
    step_w = work_q;
    step_c = cf_int_q;
    tmp    = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(rem_q)) begin
        tmp    = step1(step_w, mode_q);
        step_c = tmp[WIDTH];
        step_w = tmp[WIDTH-1:0];
      end
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    cf_int_d = cf_int_q;
    result_d = result_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    nf_d     = nf_q;

    if (enable) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            work_d   = operand;
            mode_d   = mode;
            rem_d    = amount;
            cf_int_d = 1'b0;
            if ((amount == '0) || (mode[2:1] == 2'b11)) begin
              // Nothing to shift: present the operand unchanged.
              state_d  = ST_DONE;
              result_d = operand;
              cf_d     = 1'b0;
              zf_d     = (operand == '0);
              nf_d     = operand[WIDTH-1];
            end else begin
              state_d = ST_SHIFT;
            end
          end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work_d   = step_w;
          cf_int_d = step_c;
          if (32'(rem_q) <= STEP) begin
            rem_d    = '0;
            state_d  = ST_DONE;
            result_d = step_w;
            cf_d     = step_c;
            zf_d     = (step_w == '0);
            nf_d     = step_w[WIDTH-1];
          end else begin
            rem_d = rem_q - AMT_W'(STEP);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Handshake outputs are registered images of the next state.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      mode_q   <= '0;
      rem_q    <= '0;
      cf_int_q <= 1'b0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      cf_int_q <= cf_int_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cf     = cf_q;
  assign zf     = zf_q;
  assign nf     = nf_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Self-checking bench for shift_unit_iter: one instance at STEP=1 and one at STEP=4,
// sharing clock, reset, enable and operand inputs but with separate start strobes.
module tb_shift_unit_iter;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 4;

  logic          clock   = 1'b0;
  logic          reset   = 1'b0;
  logic          enable  = 1'b1;
  logic          start1  = 1'b0;
  logic          start4  = 1'b0;
  logic [2:0]    mode    = '0;
  logic [W-1:0]  operand = '0;
  logic [AW-1:0] amount  = '0;

  logic          busy1, done1, cf1, zf1, nf1;
  logic [W-1:0]  result1;
  logic          busy4, done4, cf4, zf4, nf4;
  logic [W-1:0]  result4;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  int unsigned t0     = 0;

  bit           p_sel;
  logic [2:0]   p_mode;
  logic [W-1:0] p_op;
  int           p_amt;

  shift_unit_iter #(.WIDTH(W), .AMT_W(AW), .STEP(1)) u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .start(start1),
    .mode(mode), .operand(operand), .amount(amount),
    .busy(busy1), .done(done1), .result(result1), .cf(cf1), .zf(zf1), .nf(nf1)
  );

  shift_unit_iter #(.WIDTH(W), .AMT_W(AW), .STEP(4)) u_dut4 (
    .clock(clock), .reset(reset), .enable(enable), .start(start4),
    .mode(mode), .operand(operand), .amount(amount),
    .busy(busy4), .done(done4), .result(result4), .cf(cf4), .zf(zf4), .nf(nf4)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: shift by the full amount in one go.
  task automatic model(input logic [2:0] m, input logic [W-1:0] op, input int amt,
                       output logic [W-1:0] r, output logic c);
    r = op;
    c = 1'b0;
    if (amt != 0) begin
      case (m)
        3'd0: begin r = op << amt; c = op[W-amt]; end
        3'd1: begin r = op >> amt; c = op[amt-1]; end
        3'd2: begin r = op << amt; r[W-1] = op[W-1]; c = op[W-1-amt]; end
        3'd3: begin r = W'($signed(op) >>> amt); c = op[amt-1]; end
        3'd4: begin r = (op << amt) | (op >> (W-amt)); c = r[0]; end
        3'd5: begin r = (op >> amt) | (op << (W-amt)); c = r[W-1]; end
        default: begin r = op; c = 1'b0; end
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input bit s, input logic [2:0] m, input logic [W-1:0] op, input int amt);
    mode    = m;
    operand = op;
    amount  = AW'(amt);
    if (s) start4 = 1'b1; else start1 = 1'b1;
    p_sel  = s;
    p_mode = m;
    p_op   = op;
    p_amt  = amt;
    @(negedge clock);
    start1  = 1'b0;
    start4  = 1'b0;
    t0      = cyc;
    operand = W'($urandom);
    amount  = AW'($urandom);
    mode    = 3'($urandom);
  endtask

  task automatic finish(input string tag, input int extra);
    logic [W-1:0] er;
    logic         ec;
    int           n;
    int           guard;
    guard = 0;
    model(p_mode, p_op, p_amt, er, ec);
    if (p_amt == 0 || p_mode[2:1] == 2'b11) n = 0;
    else n = p_sel ? (p_amt + 3) / 4 : p_amt;
    while (!(p_sel ? done4 : done1) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check({tag, ".done"},   32'(p_sel ? done4 : done1), 32'd1);
    check({tag, ".lat"},    32'(cyc - t0), 32'(n + extra));
    check({tag, ".result"}, 32'(p_sel ? result4 : result1), 32'(er));
    check({tag, ".cf"},     32'(p_sel ? cf4 : cf1), 32'(ec));
    check({tag, ".zf"},     32'(p_sel ? zf4 : zf1), 32'(er == '0));
    check({tag, ".nf"},     32'(p_sel ? nf4 : nf1), 32'(er[W-1]));
  endtask

  task automatic do_op(input bit s, input logic [2:0] m, input logic [W-1:0] op,
                       input int amt, input string tag);
    launch(s, m, op, amt);
    finish(tag, 0);
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    check("rst.busy",   32'(busy1), 32'd0);
    check("rst.done",   32'(done1), 32'd0);
    check("rst.result", 32'(result1), 32'd0);
    check("rst.flags",  32'({cf1, zf1, nf1}), 32'd0);
    check("rst.busy4",  32'(busy4), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed cases
    do_op(0, 3'b001, 16'h5500, 8, "srl8");
    do_op(0, 3'b011, 16'h8001, 1, "sra1");
    do_op(0, 3'b100, 16'h8001, 4, "rol4");
    do_op(1, 3'b000, 16'h0001, 15, "sll15_s4");
    do_op(0, 3'b010, 16'hC003, 3, "sla3");
    do_op(0, 3'b101, 16'h0003, 1, "ror1");

    // Zero amount and reserved mode complete immediately without busy
    @(negedge clock);
    launch(0, 3'b001, 16'hABCD, 0);
    check("amt0.busy", 32'(busy1), 32'd0);
    finish("amt0", 0);
    @(negedge clock);
    launch(0, 3'b110, 16'h8123, 7);
    check("rsv.busy", 32'(busy1), 32'd0);
    finish("rsv", 0);
    launch(1, 3'b111, 16'h0000, 5);
    check("rsv4.busy", 32'(busy4), 32'd0);
    finish("rsv4", 0);

    // Start during SHIFT is ignored
    @(negedge clock);
    launch(0, 3'b001, 16'h8000, 5);
    check("ign.busy", 32'(busy1), 32'd1);
    operand = 16'hFFFF; amount = 4'd2; mode = 3'b000; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    finish("ign", 0);

    // Start in the DONE cycle is accepted with no bubble
    launch(0, 3'b001, 16'h0001, 1);
    check("b2b.busy", 32'(busy1), 32'd1);
    check("b2b.done", 32'(done1), 32'd0);
    finish("b2b", 0);

    // done stretches while enable is low, then drops to IDLE
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check("stretch.done", 32'(done1), 32'd1);
    check("stretch.zf",   32'(zf1), 32'd1);
    enable = 1'b1;
    @(negedge clock);
    check("stretch.idle", 32'(done1), 32'd0);

    // Enable low for three cycles mid-SHIFT
    launch(0, 3'b001, 16'h5500, 8);
    @(negedge clock);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("en.busy", 32'(busy1), 32'd1);
    end
    enable = 1'b1;
    finish("en", 3);

    // Reset mid-SHIFT clears everything immediately
    @(negedge clock);
    launch(0, 3'b011, 16'h8001, 10);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rmid.busy",   32'(busy1), 32'd0);
    check("rmid.done",   32'(done1), 32'd0);
    check("rmid.result", 32'(result1), 32'd0);
    check("rmid.flags",  32'({cf1, zf1, nf1}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rmid.idle", 32'({busy1, done1}), 32'd0);
    do_op(0, 3'b100, 16'h8001, 4, "post_rst");

    // Randomized operations on both instances
    for (int k = 0; k < 60; k++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) @(negedge clock);
      do_op(s, 3'($urandom_range(0, 7)), W'($urandom), int'($urandom_range(0, W - 1)),
            s ? "rnd4" : "rnd1");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
